// File: rtl/leb128_stream_dec.sv
// -----------------------------------------------------------------------------
// leb128_stream_dec
//
// Byte-serial LEB128 decoder. Encoded bytes arrive one per cycle on a
// valid/ready stream. Each byte carries a continuation flag (bit 7) and seven
// payload bits, least significant group first. The decoder accumulates up to
// MAXB bytes and emits one W-bit value with its byte length on a registered,
// back-pressurable output. Signed (SLEB128) or unsigned (ULEB128)
// interpretation is chosen per value by in_signed on the first byte.
//
// Malformed input is flagged on o_err:
//   - range:    the final permitted byte carries payload bits beyond W that
//               are not a proper zero/sign extension of the value;
//   - overlong: the final permitted byte still has its continuation flag set.
//               The decoder then discards bytes up to and including the next
//               byte without a continuation flag, so the stream resynchronises
//               on the next value boundary.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    encoded byte (bit 7 = continuation, bits 6:0 = payload)
//   in_valid   in_data valid
//   in_signed  1 = SLEB128, sampled with the first byte of a value
//   in_ready   byte accepted when in_valid & in_ready
//   o_data     decoded value (undefined when o_err is set)
//   o_len      number of bytes consumed by this value (1..MAXB)
//   o_err      value is malformed
//   o_valid    output valid
//   o_ready    consumer accepts when o_valid & o_ready
// -----------------------------------------------------------------------------
module leb128_stream_dec #(
    parameter int W    = 32,                 // output width, 8..64
    parameter int MAXB = (W + 6) / 7,        // derived: max encoded bytes
    parameter int LW   = $clog2(MAXB + 1)    // derived: width of o_len
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_signed,
    output logic          in_ready,
    output logic [W-1:0]  o_data,
    output logic [LW-1:0] o_len,
    output logic          o_err,
    output logic          o_valid,
    input  logic          o_ready
);

    // Payload space covered by MAXB bytes; always at least W wide.
    localparam int PW        = 7 * MAXB;
    // Bit position of payload bit 0 of the final permitted byte.
    localparam int LAST_BASE = 7 * (MAXB - 1);
    // Payload bit of the final byte that lands on value bit W-1.
    localparam int MSB_IDX   = W - 1 - LAST_BASE;

    typedef enum logic {
        ST_ACC   = 1'b0,   // accumulating a value
        ST_DRAIN = 1'b1    // discarding the tail of an overlong value
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;      // index of the next byte in the value
    logic [W-1:0]    acc_q, acc_d;      // payload gathered so far
    logic            sgn_q, sgn_d;      // sign mode latched on the first byte

    logic            o_valid_q, o_valid_d;
    logic [W-1:0]    o_data_q,  o_data_d;
    logic [LW-1:0]   o_len_q,   o_len_d;
    logic            o_err_q,   o_err_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_first;
    logic            is_last;
    logic            cur_signed;
    logic            terminate;
    logic            overlong;
    logic            range_bad;
    logic [PW-1:0]   payload_wide;
    logic [PW-1:0]   ext_mask;
    logic [W-1:0]    acc_merge;
    logic [W-1:0]    value;

    // A stalled output register blocks input, so a terminating byte can
    // never overwrite a value the consumer has not yet taken.
    assign in_ready = !o_valid_q | o_ready;
    assign accept   = in_valid & in_ready;

    assign is_first   = (cnt_q == '0);
    assign is_last    = (cnt_q == LW'(MAXB - 1));
    // The first byte of a value must use the live in_signed; later bytes use
    // the latched copy.
    assign cur_signed = is_first ? in_signed : sgn_q;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        payload_wide = PW'(in_data[6:0]) << (7 * int'(cnt_q));
        acc_merge    = acc_q | payload_wide[W-1:0];

        // Ones from bit 7*(cnt+1) upward. When the value already fills all
        // MAXB bytes the shift reaches PW and the mask is empty.
        ext_mask = {PW{1'b1}} << (7 * (int'(cnt_q) + 1));

        if (cur_signed && in_data[6]) begin
            value = acc_merge | ext_mask[W-1:0];
        end else begin
            value = acc_merge;
        end

        // Only the final permitted byte can carry bits at or beyond W. They
        // must be zero (unsigned) or copies of value bit W-1 (signed).
        range_bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (LAST_BASE + i >= W) begin
                if (cur_signed) begin
                    if (in_data[i] != in_data[MSB_IDX]) range_bad = 1'b1;
                end else begin
                    if (in_data[i]) range_bad = 1'b1;
                end
            end
        end
    end

    assign terminate = accept && (state_q == ST_ACC) && (!in_data[7] || is_last);
    assign overlong  = terminate && is_last && in_data[7];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sgn_d   = sgn_q;

        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (is_first) sgn_d = in_signed;
                    if (terminate) begin
                        // The value leaves through the output register; start
                        // the next one from a clean accumulator.
                        cnt_d = '0;
                        acc_d = '0;
                        if (overlong) state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                        acc_d = acc_merge;
                    end
                end
            end
            ST_DRAIN: begin
                // The byte without a continuation flag ends the bad value;
                // it is discarded too, and the following byte starts afresh.
                if (accept && !in_data[7]) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_len_d   = o_len_q;
        o_err_d   = o_err_q;

        if (terminate) begin
            // A handshake on the same edge is implied by accept (in_ready
            // needs o_ready while valid), so loading here replaces the
            // departing value and keeps one value per cycle.
            o_valid_d = 1'b1;
            o_data_d  = value;
            o_len_d   = cnt_q + LW'(1);
            o_err_d   = is_last && (in_data[7] || range_bad);
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d input from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            sgn_q     <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_len_q   <= '0;
            o_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sgn_q     <= sgn_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_len_q   <= o_len_d;
            o_err_q   <= o_err_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_len   = o_len_q;
    assign o_err   = o_err_q;

endmodule

// File: tb/tb_leb128_stream_dec.sv
// -----------------------------------------------------------------------------
// tb_leb128_stream_dec
//
// Bench for leb128_stream_dec. Two instances: W=32 and W=64. Expected results
// are pushed to a per-instance queue as stimulus is issued and popped by a
// monitor whenever the instance completes an output handshake. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_leb128_stream_dec;

    typedef struct {
        logic [63:0] data;
        int          len;
        bit          err;
    } exp_t;

    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // W = 32 instance
    logic [7:0]  in_data32   = '0;
    logic        in_valid32  = 1'b0;
    logic        in_signed32 = 1'b0;
    logic        in_ready32;
    logic [31:0] o_data32;
    logic [2:0]  o_len32;
    logic        o_err32;
    logic        o_valid32;
    logic        o_ready32   = 1'b1;

    // W = 64 instance
    logic [7:0]  in_data64   = '0;
    logic        in_valid64  = 1'b0;
    logic        in_signed64 = 1'b0;
    logic        in_ready64;
    logic [63:0] o_data64;
    logic [3:0]  o_len64;
    logic        o_err64;
    logic        o_valid64;
    logic        o_ready64   = 1'b1;

    leb128_stream_dec #(.W(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data32),
        .in_valid  (in_valid32),
        .in_signed (in_signed32),
        .in_ready  (in_ready32),
        .o_data    (o_data32),
        .o_len     (o_len32),
        .o_err     (o_err32),
        .o_valid   (o_valid32),
        .o_ready   (o_ready32)
    );

    leb128_stream_dec #(.W(64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data64),
        .in_valid  (in_valid64),
        .in_signed (in_signed64),
        .in_ready  (in_ready64),
        .o_data    (o_data64),
        .o_len     (o_len64),
        .o_err     (o_err64),
        .o_valid   (o_valid64),
        .o_ready   (o_ready64)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   idx32 = 0;
    int   idx64 = 0;
    int   run_len;
    int   max_run;
    int   wait_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit sel, input logic [63:0] data, input int len, input bit err);
        exp_t e;
        e.data = data;
        e.len  = len;
        e.err  = err;
        if (sel) q64.push_back(e);
        else     q32.push_back(e);
    endtask

    // Present one byte and return 1 time unit after the edge that accepts it.
    task automatic send_byte(input bit sel, input logic [7:0] b, input logic sgn);
        int  waited = 0;
        bit  done   = 1'b0;
        if (sel) begin
            in_data64 = b; in_signed64 = sgn; in_valid64 = 1'b1;
        end else begin
            in_data32 = b; in_signed32 = sgn; in_valid32 = 1'b1;
        end
        while (!done) begin
            @(negedge clk);
            if (sel ? in_ready64 : in_ready32) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > TIMEOUT) begin
                    check("in_ready_wait_cycles", 64'(waited), 64'(TIMEOUT));
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input bit sel);
        if (sel) in_valid64 = 1'b0;
        else     in_valid32 = 1'b0;
    endtask

    task automatic send_seq(input bit sel, input logic [7:0] bytes[$], input logic sgn);
        foreach (bytes[i]) send_byte(sel, bytes[i], sgn);
        idle(sel);
    endtask

    // Wait (bounded) until every expected output has been observed.
    task automatic wait_empty(input bit sel, input string tag);
        for (int i = 0; i < 100; i++) begin
            if ((sel ? q64.size() : q32.size()) == 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check(tag, 64'(sel ? q64.size() : q32.size()), 64'd0);
    endtask

    // Scoreboard monitors: compare on each output handshake.
    always @(negedge clk) begin
        if (rst_n && o_valid32 && o_ready32) begin
            if (q32.size() == 0) begin
                check("dut32_unexpected_output_valid", 64'(o_valid32), 64'd0);
            end else begin
                e32 = q32.pop_front();
                check($sformatf("dut32_len[%0d]", idx32), 64'(o_len32), 64'(e32.len));
                check($sformatf("dut32_err[%0d]", idx32), 64'(o_err32), 64'(e32.err));
                if (!e32.err)
                    check($sformatf("dut32_data[%0d]", idx32), 64'(o_data32), e32.data);
                idx32++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_valid64 && o_ready64) begin
            if (q64.size() == 0) begin
                check("dut64_unexpected_output_valid", 64'(o_valid64), 64'd0);
            end else begin
                e64 = q64.pop_front();
                check($sformatf("dut64_len[%0d]", idx64), 64'(o_len64), 64'(e64.len));
                check($sformatf("dut64_err[%0d]", idx64), 64'(o_err64), 64'(e64.err));
                if (!e64.err)
                    check($sformatf("dut64_data[%0d]", idx64), o_data64, e64.data);
                idx64++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid32", 64'(o_valid32), 64'd0);
        check("rst_o_data32",  64'(o_data32),  64'd0);
        check("rst_o_len32",   64'(o_len32),   64'd0);
        check("rst_o_err32",   64'(o_err32),   64'd0);
        check("rst_in_ready32", 64'(in_ready32), 64'd1);
        check("rst_o_valid64", 64'(o_valid64), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- 1: unsigned multi-byte, latency ----------------
        push_exp(0, 64'h0000_0000_0009_8765, 3, 0);
        send_byte(0, 8'hE5, 1'b0);
        send_byte(0, 8'h8E, 1'b0);
        check("t1_no_early_valid", 64'(o_valid32), 64'd0);
        send_byte(0, 8'h26, 1'b0);
        check("t1_valid_one_cycle_after", 64'(o_valid32), 64'd1);
        idle(0);
        wait_empty(0, "t1_queue_empty");

        // ---------------- 2: signed values and sign-extension boundary ------
        push_exp(0, 64'h0000_0000_FFFE_1DC0, 3, 0);
        push_exp(0, 64'h0000_0000_FFFF_FFFF, 1, 0);
        push_exp(0, 64'h0000_0000_0000_003F, 1, 0);
        push_exp(0, 64'h0000_0000_FFFF_FFC0, 1, 0);
        send_seq(0, '{8'hC0, 8'hBB, 8'h78, 8'h7F, 8'h3F, 8'h40}, 1'b1);
        push_exp(0, 64'h0000_0000_0000_007F, 1, 0);
        send_seq(0, '{8'h7F}, 1'b0);
        wait_empty(0, "t2_queue_empty");

        // ---------------- 3: five-byte range boundary ----------------
        push_exp(0, 64'h0000_0000_FFFF_FFFF, 5, 0);
        push_exp(0, 64'h0,                   5, 1);
        send_seq(0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F,
                      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F}, 1'b0);
        push_exp(0, 64'h0000_0000_FFFF_FFFF, 5, 0);
        send_seq(0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F}, 1'b1);
        wait_empty(0, "t3_queue_empty");

        // ---------------- 4: overlong and resync ----------------
        push_exp(0, 64'h0, 5, 1);
        push_exp(0, 64'h0000_0000_0000_0005, 1, 0);
        send_seq(0, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h05}, 1'b0);
        wait_empty(0, "t4_queue_empty");

        // ---------------- 5a: output stall ----------------
        o_ready32 = 1'b0;
        push_exp(0, 64'd1, 1, 0);
        push_exp(0, 64'd2, 1, 0);
        push_exp(0, 64'd3, 1, 0);
        fork
            send_seq(0, '{8'h01, 8'h02, 8'h03}, 1'b0);
            begin
                wait_cnt = 0;
                @(negedge clk);
                while (!o_valid32 && wait_cnt < 20) begin
                    wait_cnt++;
                    @(negedge clk);
                end
                check("t5_stall_valid_seen", 64'(o_valid32), 64'd1);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    check($sformatf("t5_stall_in_ready[%0d]", k), 64'(in_ready32), 64'd0);
                    check($sformatf("t5_stall_hold_data[%0d]", k), 64'(o_data32), 64'd1);
                end
                @(posedge clk);
                #1;
                o_ready32 = 1'b1;
            end
        join
        wait_empty(0, "t5_stall_queue_empty");

        // ---------------- 5b: full throughput ----------------
        push_exp(0, 64'd1, 1, 0);
        push_exp(0, 64'd2, 1, 0);
        push_exp(0, 64'd3, 1, 0);
        run_len = 0;
        max_run = 0;
        fork
            send_seq(0, '{8'h01, 8'h02, 8'h03}, 1'b0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (o_valid32) begin
                        run_len++;
                        if (run_len > max_run) max_run = run_len;
                    end else begin
                        run_len = 0;
                    end
                end
            end
        join
        check("t5_consecutive_valid", 64'(max_run), 64'd3);
        wait_empty(0, "t5_tput_queue_empty");

        // ---------------- 6: W=64 ten-byte signed ----------------
        push_exp(1, 64'h8000_0000_0000_0000, 10, 0);
        send_seq(1, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                      8'h80, 8'h80, 8'h80, 8'h80, 8'h7F}, 1'b1);
        wait_empty(1, "t6_queue_empty");

        // ---------------- 6: reset mid-value ----------------
        send_seq(1, '{8'h80, 8'h80, 8'h80}, 1'b0);
        rst_n = 1'b0;
        #3;
        check("t6_rst_o_valid64", 64'(o_valid64), 64'd0);
        check("t6_rst_o_data64",  o_data64,       64'd0);
        check("t6_rst_o_len64",   64'(o_len64),   64'd0);
        check("t6_rst_o_err64",   64'(o_err64),   64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(1, 64'd5, 1, 0);
        send_seq(1, '{8'h05}, 1'b0);
        wait_empty(1, "t6_post_reset_queue_empty");

        repeat (3) @(posedge clk);
        #1;
        check("final_q32_empty", 64'(q32.size()), 64'd0);
        check("final_q64_empty", 64'(q64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
